pipe_ctrl: RTL and testbench

- Central hazard and stall controller for the five-stage pipeline.
- Drives hold_n (freeze) and flush (bubble insert) for every pipeline register: if_id, id_ex, ex_mem, mem_wb.
- Drives PC hold and PC source select.
- Resolves load-use hazards, EX-stage redirects, traps, instruction-fetch waits and multi-cycle data-memory waits, with a timeout and a stall performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 18 +
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int MEM_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        PC_SEL_SEQ   = 2'b00,
        PC_SEL_REDIR = 2'b01,
        PC_SEL_TRAP  = 2'b10
    } pc_sel_e;

    typedef enum logic {
        PIPE_RUN      = 1'b0,
        PIPE_MEM_WAIT = 1'b1
    } pipe_state_e;

    typedef struct packed {
        logic    pc_hold_n;
        pc_sel_e pc_sel;
        logic    if_id_hold_n;
        logic    id_ex_hold_n;
        logic    ex_mem_hold_n;
        logic    mem_wb_hold_n;
        logic    if_id_flush;
        logic    id_ex_flush;
        logic    ex_mem_flush;
        logic    mem_wb_flush;
        logic    mem_timeout_err;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the pipeline stages and the hold/flush/PC controls back to them.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd_addr;
    logic             ex_load;
    logic             ex_redirect;
    logic             trap_req;
    logic             if_ack;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_hold_n;
    logic [1:0]       pc_sel;
    logic             if_id_hold_n;
    logic             id_ex_hold_n;
    logic             ex_mem_hold_n;
    logic             mem_wb_hold_n;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_rd_addr, ex_load, ex_redirect, trap_req, if_ack, mem_req, mem_ack,
        output pc_hold_n, pc_sel, if_id_hold_n, id_ex_hold_n, ex_mem_hold_n, mem_wb_hold_n,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout_err, stall_cnt
    );

    modport slave (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_rd_addr, ex_load, ex_redirect, trap_req, if_ack, mem_req, mem_ack,
        input  pc_hold_n, pc_sel, if_id_hold_n, id_ex_hold_n, ex_mem_hold_n, mem_wb_hold_n,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout_err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: ID reads a register that the load now in EX has yet to produce.
// Purely combinational; x0 never creates a hazard.
module hazard_detect (
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_load_i,
    output logic       load_use_o
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    assign load_use_o = ex_load_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/stall controller: per-stage hold_n/flush, PC hold and PC source select,
// data-memory wait FSM with timeout, deferred trap and stall performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 32,
    parameter int WAIT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.master bus
);
    pipe_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              trap_pend_q, trap_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic  load_use;
    logic  timeout_hit;
    logic  mem_stall;
    logic  trap_any;
    ctrl_t ctrl;

    hazard_detect u_hazard_detect (
        .id_rs1_addr_i (bus.id_rs1_addr),
        .id_rs2_addr_i (bus.id_rs2_addr),
        .id_rs1_used_i (bus.id_rs1_used),
        .id_rs2_used_i (bus.id_rs2_used),
        .ex_rd_addr_i  (bus.ex_rd_addr),
        .ex_load_i     (bus.ex_load),
        .load_use_o    (load_use)
    );

    assign timeout_hit = (state_q == PIPE_MEM_WAIT) &&
                         (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) && !bus.mem_ack;
    assign mem_stall   = bus.mem_req && !bus.mem_ack && !timeout_hit;
    assign trap_any    = bus.trap_req || trap_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PIPE_RUN;
            wait_cnt_q  <= '0;
            trap_pend_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            trap_pend_q <= trap_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        trap_pend_d = trap_pend_q;
        unique case (state_q)
            PIPE_RUN: begin
                if (mem_stall) begin
                    state_d    = PIPE_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            PIPE_MEM_WAIT: begin
                if (mem_stall) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    state_d    = PIPE_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = PIPE_RUN;
                wait_cnt_d = '0;
            end
        endcase
        // A trap raised while MEM is frozen is replayed on the release cycle.
        if (mem_stall) begin
            if (bus.trap_req) begin
                trap_pend_d = 1'b1;
            end
        end else begin
            trap_pend_d = 1'b0;
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(!ctrl.pc_hold_n);
    end

    always_comb begin
        ctrl                 = '0;
        ctrl.pc_hold_n       = 1'b1;
        ctrl.pc_sel          = PC_SEL_SEQ;
        ctrl.if_id_hold_n    = 1'b1;
        ctrl.id_ex_hold_n    = 1'b1;
        ctrl.ex_mem_hold_n   = 1'b1;
        ctrl.mem_wb_hold_n   = 1'b1;
        if (rst) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else begin
            ctrl.mem_timeout_err = timeout_hit;
            if (mem_stall) begin
                ctrl.pc_hold_n     = 1'b0;
                ctrl.if_id_hold_n  = 1'b0;
                ctrl.id_ex_hold_n  = 1'b0;
                ctrl.ex_mem_hold_n = 1'b0;
                ctrl.mem_wb_flush  = 1'b1;
            end else if (trap_any) begin
                ctrl.pc_sel       = PC_SEL_TRAP;
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
            end else if (bus.ex_redirect) begin
                ctrl.pc_sel      = PC_SEL_REDIR;
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end else if (load_use) begin
                ctrl.pc_hold_n    = 1'b0;
                ctrl.if_id_hold_n = 1'b0;
                ctrl.id_ex_flush  = 1'b1;
            end else if (!bus.if_ack) begin
                ctrl.pc_hold_n   = 1'b0;
                ctrl.if_id_flush = 1'b1;
            end
        end
    end

    assign bus.pc_hold_n       = ctrl.pc_hold_n;
    assign bus.pc_sel          = ctrl.pc_sel;
    assign bus.if_id_hold_n    = ctrl.if_id_hold_n;
    assign bus.id_ex_hold_n    = ctrl.id_ex_hold_n;
    assign bus.ex_mem_hold_n   = ctrl.ex_mem_hold_n;
    assign bus.mem_wb_hold_n   = ctrl.mem_wb_hold_n;
    assign bus.if_id_flush     = ctrl.if_id_flush;
    assign bus.id_ex_flush     = ctrl.id_ex_flush;
    assign bus.ex_mem_flush    = ctrl.ex_mem_flush;
    assign bus.mem_wb_flush    = ctrl.mem_wb_flush;
    assign bus.mem_timeout_err = ctrl.mem_timeout_err;
    assign bus.stall_cnt       = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of single-cycle hazard vectors plus
// hand-written memory-wait, trap, timeout and reset sequences.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    // {pc_hold_n, pc_sel[1:0], if_id/id_ex/ex_mem/mem_wb hold_n, if_id/id_ex/ex_mem/mem_wb flush, err}
    localparam logic [11:0] O_IDLE   = 12'b1_00_1111_0000_0;
    localparam logic [11:0] O_MSTALL = 12'b0_00_0001_0001_0;
    localparam logic [11:0] O_TRAP   = 12'b1_10_1111_1110_0;
    localparam logic [11:0] O_REDIR  = 12'b1_01_1111_1100_0;
    localparam logic [11:0] O_LU     = 12'b0_00_0111_0100_0;
    localparam logic [11:0] O_NOACK  = 12'b0_00_1111_1000_0;
    localparam logic [11:0] O_RST    = 12'b1_00_1111_1111_0;
    localparam logic [11:0] O_TO     = 12'b1_00_1111_0000_1;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        ld;
        logic        redir;
        logic        trap;
        logic        ifack;
        logic        mreq;
        logic        mack;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(32)) ifc ();

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32), .WAIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_stall = '0;
    logic [11:0] exp_q[$];
    vec_t        tbl[13];

    function automatic logic [11:0] outs();
        return {ifc.pc_hold_n, ifc.pc_sel, ifc.if_id_hold_n, ifc.id_ex_hold_n,
                ifc.ex_mem_hold_n, ifc.mem_wb_hold_n, ifc.if_id_flush, ifc.id_ex_flush,
                ifc.ex_mem_flush, ifc.mem_wb_flush, ifc.mem_timeout_err};
    endfunction

    task automatic drive(input vec_t v);
        ifc.id_rs1_addr = v.rs1;
        ifc.id_rs2_addr = v.rs2;
        ifc.id_rs1_used = v.u1;
        ifc.id_rs2_used = v.u2;
        ifc.ex_rd_addr  = v.rd;
        ifc.ex_load     = v.ld;
        ifc.ex_redirect = v.redir;
        ifc.trap_req    = v.trap;
        ifc.if_ack      = v.ifack;
        ifc.mem_req     = v.mreq;
        ifc.mem_ack     = v.mack;
    endtask

    task automatic idle_in();
        vec_t v;
        v       = '0;
        v.ifack = 1'b1;
        drive(v);
    endtask

    // Expected value queued when stimulus is applied, popped when the outputs are sampled.
    task automatic step(input logic [11:0] e, input string nm);
        logic [11:0] got;
        logic [11:0] want;
        exp_q.push_back(e);
        if (!e[11] && !rst) exp_stall = exp_stall + 32'd1;
        @(negedge clk);
        got  = outs();
        want = exp_q.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: outputs=%b expected=%b", nm, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    initial begin
        //            rs1    rs2    u1    u2    rd     ld    rdr   trp   ifa   mrq   mak   exp
        tbl[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
        tbl[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
        tbl[2]  = '{5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
        tbl[3]  = '{5'd3,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
        tbl[4]  = '{5'd3,  5'd9,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
        tbl[5]  = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
        tbl[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_REDIR};
        tbl[7]  = '{5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_REDIR};
        tbl[8]  = '{5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_TRAP};
        tbl[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NOACK};
        tbl[10] = '{5'd31, 5'd0,  1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_IDLE};
        tbl[12] = '{5'd2,  5'd4,  1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_LU};

        rst = 1'b1;
        idle_in();
        step(O_RST, "reset_outputs");
        chk("reset_stall_cnt", ifc.stall_cnt, 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(PIPE_RUN));
        exp_stall = '0;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            step(tbl[i].exp, $sformatf("vec%0d", i));
        end
        chk("table_state_run", 32'(dut.state_q), 32'(PIPE_RUN));
        chk("table_stall_cnt", ifc.stall_cnt, exp_stall);

        // Three-cycle data-memory wait released by ack.
        idle_in();
        ifc.mem_req = 1'b1;
        step(O_MSTALL, "memwait_c1");
        chk("memwait_state", 32'(dut.state_q), 32'(PIPE_MEM_WAIT));
        step(O_MSTALL, "memwait_c2");
        step(O_MSTALL, "memwait_c3");
        ifc.mem_ack = 1'b1;
        step(O_IDLE, "memwait_release");
        chk("memwait_back_run", 32'(dut.state_q), 32'(PIPE_RUN));
        chk("memwait_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        chk("memwait_stall_cnt", ifc.stall_cnt, exp_stall);

        // Redirect held through a wait is applied on the release cycle.
        idle_in();
        ifc.mem_req     = 1'b1;
        ifc.ex_redirect = 1'b1;
        step(O_MSTALL, "redir_wait");
        ifc.mem_ack = 1'b1;
        step(O_REDIR, "redir_release");

        // Trap arriving mid-wait is deferred to the release cycle.
        idle_in();
        ifc.mem_req = 1'b1;
        step(O_MSTALL, "trapwait_c1");
        ifc.trap_req = 1'b1;
        step(O_MSTALL, "trapwait_c2");
        chk("trap_pend_set", 32'(dut.trap_pend_q), 32'd1);
        ifc.trap_req = 1'b0;
        step(O_MSTALL, "trapwait_c3");
        ifc.mem_ack = 1'b1;
        step(O_TRAP, "trap_on_release");
        chk("trap_pend_clear", 32'(dut.trap_pend_q), 32'd0);
        idle_in();
        step(O_IDLE, "after_trap");

        // Timeout: ack never comes.
        ifc.mem_req = 1'b1;
        step(O_MSTALL, "timeout_c1");
        step(O_MSTALL, "timeout_c2");
        step(O_MSTALL, "timeout_c3");
        step(O_TO, "timeout_pulse");
        chk("timeout_state_run", 32'(dut.state_q), 32'(PIPE_RUN));
        ifc.mem_req = 1'b0;
        step(O_IDLE, "timeout_after");
        chk("timeout_stall_cnt", ifc.stall_cnt, exp_stall);

        // Reset in the middle of a wait discards the pending trap.
        ifc.mem_req  = 1'b1;
        ifc.trap_req = 1'b1;
        step(O_MSTALL, "rstwait_c1");
        ifc.trap_req = 1'b0;
        rst = 1'b1;
        step(O_RST, "rstwait_outputs");
        exp_stall = '0;
        chk("rstwait_stall_cnt", ifc.stall_cnt, 32'd0);
        chk("rstwait_trap_pend", 32'(dut.trap_pend_q), 32'd0);
        rst = 1'b0;
        idle_in();
        chk("rstwait_state", 32'(dut.state_q), 32'(PIPE_RUN));
        chk("rstwait_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        step(O_IDLE, "post_reset_no_trap");
        chk("final_stall_cnt", ifc.stall_cnt, exp_stall);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
